// File: rtl/imem_port_arbiter.sv
// Arbitrates the single combinational instruction-ROM read port between fetch and debug.
// Optional grant/conflict statistics are enabled by defining IMEM_ARB_STATS_EN.
module imem_port_arbiter #(
  parameter int unsigned DEPTH      = 10,
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] OOR_DATA   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        rerr,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0] f_gnt_cnt,
  output logic [15:0] d_gnt_cnt,
  output logic [15:0] conflict_cnt
`endif
);

  typedef enum logic {StNormal, StForceD} arbState_e;

  localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);
  localparam logic [31:0] Depth     = 32'(DEPTH);

  arbState_e   state;
  logic [3:0]  starveCnt;
  logic [3:0]  starveNext;
  logic        dWins;
  logic        anyGnt;
  logic        grantErr;
  logic [31:0] grantData;

  // Grant decision is purely a function of requests and the registered arbitration state.
  always_comb begin
    dWins = 1'b0;
    unique case (state)
      StForceD: dWins = d_req;
      default:  dWins = d_req & ~f_req;
    endcase
  end

  assign d_gnt     = dWins;
  assign f_gnt     = (state == StNormal) & f_req;
  assign anyGnt    = f_gnt | d_gnt;
  assign mem_addr  = dWins ? d_addr : f_addr;
  assign grantErr  = (mem_addr >= Depth);
  assign grantData = grantErr ? OOR_DATA : mem_data;

  always_comb begin
    starveNext = 4'd0;
    if (d_req && !d_gnt) begin
      starveNext = (starveCnt >= StarveMax) ? StarveMax : starveCnt + 4'd1;
    end
  end

  // Forcing is decided on the edge where the counter reaches its limit, so debug wins next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StNormal;
      starveCnt <= 4'd0;
    end else begin
      starveCnt <= starveNext;
      unique case (state)
        StNormal: begin
          if (starveNext == StarveMax) state <= StForceD;
        end
        StForceD: begin
          if (d_gnt || !d_req) state <= StNormal;
        end
        default: state <= StNormal;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      f_rdata  <= 32'h0;
      d_rdata  <= 32'h0;
      rerr     <= 1'b0;
    end else begin
      f_rvalid <= f_gnt;
      d_rvalid <= d_gnt;
      rerr     <= anyGnt & grantErr;
      if (f_gnt) f_rdata <= grantData;
      if (d_gnt) d_rdata <= grantData;
    end
  end

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_gnt_cnt    <= 16'h0;
      d_gnt_cnt    <= 16'h0;
      conflict_cnt <= 16'h0;
    end else begin
      if (f_gnt) f_gnt_cnt <= f_gnt_cnt + 16'd1;
      if (d_gnt) d_gnt_cnt <= d_gnt_cnt + 16'd1;
      if (f_req && d_req && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a response scoreboard queue.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        rerr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0] f_gnt_cnt;
  logic [15:0] d_gnt_cnt;
  logic [15:0] conflict_cnt;
`endif

  typedef struct packed {
    logic        dbg;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t respQ[$];
  int    tests = 0;
  int    fails = 0;

  imem_port_arbiter #(
    .DEPTH     (10),
    .STARVE_MAX(4),
    .OOR_DATA  (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_rvalid(f_rvalid),
    .f_rdata (f_rdata),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .rerr    (rerr),
    .mem_addr(mem_addr),
    .mem_data(mem_data)
`ifdef IMEM_ARB_STATS_EN
    ,
    .f_gnt_cnt   (f_gnt_cnt),
    .d_gnt_cnt   (d_gnt_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  // ROM model: word k holds k+1000; out-of-range returns a marker the DUT must ignore.
  assign mem_data = (mem_addr < 32'd10) ? mem_addr + 32'd1000 : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleResp(input string tag);
    check({tag, " f_rvalid"}, 32'(f_rvalid), 32'd0);
    check({tag, " d_rvalid"}, 32'(d_rvalid), 32'd0);
    check({tag, " rerr"}, 32'(rerr), 32'd0);
  endtask

  // One cycle: drive, check grants and ROM address, then check the response after the edge.
  task automatic step(input string tag, input logic fr, input logic [31:0] fa,
                      input logic dr, input logic [31:0] da,
                      input logic expF, input logic expD);
    resp_t e;
    logic [31:0] addr;
    @(negedge clk);
    f_req  = fr;
    f_addr = fa;
    d_req  = dr;
    d_addr = da;
    #1;
    addr = expD ? da : fa;
    check({tag, " f_gnt"}, 32'(f_gnt), 32'(expF));
    check({tag, " d_gnt"}, 32'(d_gnt), 32'(expD));
    check({tag, " mem_addr"}, mem_addr, addr);
    if (expF || expD) begin
      e.dbg  = expD;
      e.err  = (addr >= 32'd10);
      e.data = e.err ? 32'h0 : addr + 32'd1000;
      respQ.push_back(e);
    end
    @(posedge clk);
    #1;
    if (respQ.size() > 0) begin
      e = respQ.pop_front();
      check({tag, " f_rvalid"}, 32'(f_rvalid), 32'(!e.dbg));
      check({tag, " d_rvalid"}, 32'(d_rvalid), 32'(e.dbg));
      check({tag, " rerr"}, 32'(rerr), 32'(e.err));
      if (e.dbg) check({tag, " d_rdata"}, d_rdata, e.data);
      else       check({tag, " f_rdata"}, f_rdata, e.data);
    end else begin
      checkIdleResp(tag);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkIdleResp(tag);
    check({tag, " f_rdata"}, f_rdata, 32'h0);
    check({tag, " d_rdata"}, d_rdata, 32'h0);
    check({tag, " f_gnt"}, 32'(f_gnt), 32'd0);
    check({tag, " d_gnt"}, 32'(d_gnt), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    f_req = 1'b0;
    d_req = 1'b0;
    respQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    f_req  = 1'b0;
    f_addr = 32'h0;
    d_req  = 1'b0;
    d_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch only, addresses 0..9 back to back.
    for (int k = 0; k < 10; k++) step($sformatf("fetch%0d", k), 1'b1, 32'(k), 1'b0, 32'h0, 1'b1, 1'b0);

    // Debug only.
    step("dbg_only", 1'b0, 32'h0, 1'b1, 32'd3, 1'b0, 1'b1);
    step("idle", 1'b0, 32'd6, 1'b0, 32'h0, 1'b0, 1'b0);
    check("fetch_rdata_held", f_rdata, 32'd1009);

    // Starvation: fetch wins four times, debug forced on the fifth, twice over.
    for (int c = 0; c < 10; c++) begin
      step($sformatf("starve%0d", c), 1'b1, 32'd5, 1'b1, 32'd7, (c % 5) != 4, (c % 5) == 4);
    end
    step("starve_drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Out-of-range addresses.
    step("oor10", 1'b1, 32'd10, 1'b0, 32'h0, 1'b1, 1'b0);
    step("oor_max", 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 1'b0);
    step("dbg_oor", 1'b0, 32'h0, 1'b1, 32'd12, 1'b0, 1'b1);
    step("after_oor", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset while a debug response is in flight.
    @(negedge clk);
    d_req  = 1'b1;
    d_addr = 32'd2;
    #1;
    check("midrst d_gnt", 32'(d_gnt), 32'd1);
    #1;
    rst_n = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    checkResetOutputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b0, 32'h0, 1'b1, 32'd2, 1'b0, 1'b1);
    step("post_rst_f", 1'b1, 32'd8, 1'b0, 32'h0, 1'b1, 1'b0);

`ifdef IMEM_ARB_STATS_EN
    pulseReset();
    for (int c = 0; c < 6; c++) begin
      step($sformatf("stats%0d", c), 1'b1, 32'd1, 1'b1, 32'd4, c != 4, c == 4);
    end
    check("f_gnt_cnt", 32'(f_gnt_cnt), 32'd5);
    check("d_gnt_cnt", 32'(d_gnt_cnt), 32'd1);
    check("conflict_cnt", 32'(conflict_cnt), 32'd6);
    step("stats_drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
`else
    pulseReset();
    step("rst2_first", 1'b1, 32'd0, 1'b1, 32'd4, 1'b1, 1'b0);
    step("rst2_drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
